// File: rtl/sysmem_fb_pkg.sv
// Shared definitions for the system-memory to frame-buffer copy engine.
// Holds the FSM state encoding, the pixel width and the default image size.
package sysmem_fb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_CAP,
    WR,
    DONE
  } state_t;

  localparam int PIX_W             = 24;
  localparam int DEFAULT_NUM_WORDS = 100;

endpackage

// File: rtl/sysmem_fb_transfer.sv
// sysmem_fb_transfer
// Copies NUM_WORDS RGB words from system memory into the display frame buffer.
// Each word is read (RD_REQ), captured (RD_CAP), and then written with a
// WEFB/FBReady handshake (WR). Done pulses once after the last accepted write.
// Optional feature: define SYSMEM_FB_CHECKSUM_EN to add the o_checksum port,
// a running modulo-2**DW sum of every word accepted by the frame buffer.
module sysmem_fb_transfer
  import sysmem_fb_pkg::*;
#(
  parameter int NUM_WORDS = DEFAULT_NUM_WORDS,
  parameter int SM_AW     = 7,
  parameter int FB_AW     = 7,
  parameter int DW        = PIX_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_resm,
  output logic [SM_AW-1:0] o_addrSm,
  input  logic [DW-1:0]    i_wData,
  output logic             o_wefb,
  output logic [FB_AW-1:0] o_addrFb,
  output logic [DW-1:0]    o_fbData,
  input  logic             i_fbReady
`ifdef SYSMEM_FB_CHECKSUM_EN
  ,
  output logic [DW-1:0]    o_checksum
`endif
);

  localparam logic [SM_AW-1:0] LAST_IDX = SM_AW'(NUM_WORDS - 1);

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_resm;
  logic               r_wefb;
  logic [SM_AW-1:0]   r_index;
  logic [DW-1:0]      r_fbData;

  logic               w_accept;
  logic               w_lastWord;

  assign w_accept   = r_wefb && i_fbReady;
  assign w_lastWord = (r_index == LAST_IDX);

  // The index is both the read address and the write address of the current word.
  assign o_addrSm = r_index;
  assign o_addrFb = FB_AW'(r_index);
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_resm   = r_resm;
  assign o_wefb   = r_wefb;
  assign o_fbData = r_fbData;

  // Transfer FSM with registered strobes, index counter and captured write data.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_resm   <= 1'b0;
      r_wefb   <= 1'b0;
      r_index  <= '0;
      r_fbData <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= RD_REQ;
            r_index <= '0;
            r_busy  <= 1'b1;
            r_resm  <= 1'b1;
          end
        end
        RD_REQ: begin
          r_state <= RD_CAP;
          r_resm  <= 1'b0;
        end
        RD_CAP: begin
          r_state  <= WR;
          r_fbData <= i_wData;
          r_wefb   <= 1'b1;
        end
        WR: begin
          if (w_accept) begin
            r_wefb <= 1'b0;
            if (w_lastWord) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= RD_REQ;
              r_index <= r_index + 1'b1;
              r_resm  <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef SYSMEM_FB_CHECKSUM_EN
  logic [DW-1:0] r_checksum;

  assign o_checksum = r_checksum;

  // Running sum of accepted words; cleared when a new transfer is accepted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_checksum <= '0;
    end else if (r_state == IDLE && i_start) begin
      r_checksum <= '0;
    end else if (r_state == WR && w_accept) begin
      r_checksum <= r_checksum + r_fbData;
    end
  end
`endif

endmodule

// File: tb/tb_sysmem_fb_transfer.sv
// Directed testbench for sysmem_fb_transfer.
// Build with SYSMEM_FB_CHECKSUM_EN defined to also exercise the checksum port.
module tb_sysmem_fb_transfer;
  import sysmem_fb_pkg::*;

  localparam int NW    = 100;
  localparam int SM_AW = 7;
  localparam int FB_AW = 7;
  localparam int DW    = 24;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             busy, done, resm, wefb;
  logic [SM_AW-1:0] addrSm;
  logic [DW-1:0]    wData;
  logic [FB_AW-1:0] addrFb;
  logic [DW-1:0]    fbData;
  logic             fbReady;
`ifdef SYSMEM_FB_CHECKSUM_EN
  logic [DW-1:0]    checksum;
`endif

  // Single-word instance
  logic             start1;
  logic             s1Busy, s1Done, s1Resm, s1Wefb;
  logic [2:0]       s1AddrSm;
  logic [DW-1:0]    s1WData;
  logic [1:0]       s1AddrFb;
  logic [DW-1:0]    s1FbData;
`ifdef SYSMEM_FB_CHECKSUM_EN
  logic [DW-1:0]    s1Checksum;
`endif

  logic [DW-1:0]    mem [0:127];
  bit               altPattern;

  int               errors = 0;
  int               checks = 0;
  int               cyc = 0;
  int               startCyc;
  int               doneCyc;
  int               doneCount;
  int               busyCount;
  bit               timedOut;
  logic [FB_AW-1:0] wrAddr [$];
  logic [DW-1:0]    wrData [$];
  logic [SM_AW-1:0] rdAddr [$];
  logic             stWe   [$];
  logic [FB_AW-1:0] stAddr [$];
  logic [DW-1:0]    stData [$];

  sysmem_fb_transfer #(
    .NUM_WORDS(NW), .SM_AW(SM_AW), .FB_AW(FB_AW), .DW(DW)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .o_busy(busy), .o_done(done), .o_resm(resm), .o_addrSm(addrSm),
    .i_wData(wData), .o_wefb(wefb), .o_addrFb(addrFb), .o_fbData(fbData),
    .i_fbReady(fbReady)
`ifdef SYSMEM_FB_CHECKSUM_EN
    , .o_checksum(checksum)
`endif
  );

  sysmem_fb_transfer #(
    .NUM_WORDS(1), .SM_AW(3), .FB_AW(2), .DW(DW)
  ) dut1 (
    .i_clk(clk), .i_reset(reset), .i_start(start1),
    .o_busy(s1Busy), .o_done(s1Done), .o_resm(s1Resm), .o_addrSm(s1AddrSm),
    .i_wData(s1WData), .o_wefb(s1Wefb), .o_addrFb(s1AddrFb), .o_fbData(s1FbData),
    .i_fbReady(1'b1)
`ifdef SYSMEM_FB_CHECKSUM_EN
    , .o_checksum(s1Checksum)
`endif
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  // System memory model: data valid the cycle after RESM
  always @(posedge clk) begin
    if (resm) wData <= mem[addrSm];
    if (s1Resm) s1WData <= 24'hABCDEF ^ {21'b0, s1AddrSm};
  end

  // Monitor of writes, reads, Done pulses and Busy cycles
  always @(negedge clk) begin
    if (wefb && fbReady) begin
      wrAddr.push_back(addrFb);
      wrData.push_back(fbData);
    end
    if (resm) rdAddr.push_back(addrSm);
    if (done) begin
      doneCount = doneCount + 1;
      doneCyc = cyc;
    end
    if (busy) busyCount = busyCount + 1;
  end

  // Watchdog
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DW-1:0] expWord(input int i);
    logic [DW-1:0] v;
    v = altPattern ? (DW'(i * 66311) ^ 24'h5A3C0F) : DW'(i);
    return v;
  endfunction

  task automatic loadMem();
    for (int i = 0; i < 128; i++) mem[i] = expWord(i);
  endtask

  // Runs one transfer; optional stall, re-Start and reset injection points
  task automatic applyStimulus(input int stallWord, input int stallLen,
                               input int restartWord, input int resetWord,
                               input int budget);
    int n;
    int stalled;
    bit restarted;
    bit fired;
    wrAddr.delete(); wrData.delete(); rdAddr.delete();
    stWe.delete(); stAddr.delete(); stData.delete();
    doneCount = 0; busyCount = 0; timedOut = 0; doneCyc = -1;
    @(posedge clk); #1;
    start = 1'b1; fbReady = 1'b1; startCyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; stalled = 0; restarted = 0; fired = 0;
    while (!fired && doneCount == 0 && n < budget) begin
      fbReady = 1'b1;
      start = 1'b0;
      if (wefb && int'(addrFb) == stallWord && stalled < stallLen) begin
        fbReady = 1'b0;
        stalled++;
        stWe.push_back(wefb);
        stAddr.push_back(addrFb);
        stData.push_back(fbData);
      end
      if (wefb && int'(addrFb) == restartWord && !restarted) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      if (resm && int'(addrSm) == resetWord) begin
        reset = 1'b1;
        fired = 1'b1;
      end
      if (!fired) begin
        @(posedge clk); #1;
        n++;
      end
    end
    start = 1'b0;
    fbReady = 1'b1;
    timedOut = (n >= budget) && !fired && (doneCount == 0);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; start1 = 1'b0; fbReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0;
    checks++; if (dut.r_state !== IDLE) begin errors++; $display("[TB] FAIL reset_state: got %0d expected %0d", dut.r_state, IDLE); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (resm !== 1'b0) begin errors++; $display("[TB] FAIL reset_resm: got %b expected 0", resm); end
    checks++; if (wefb !== 1'b0) begin errors++; $display("[TB] FAIL reset_wefb: got %b expected 0", wefb); end
    checks++; if (addrSm !== '0) begin errors++; $display("[TB] FAIL reset_addrSm: got %0d expected 0", addrSm); end
    checks++; if (addrFb !== '0) begin errors++; $display("[TB] FAIL reset_addrFb: got %0d expected 0", addrFb); end
    checks++; if (fbData !== '0) begin errors++; $display("[TB] FAIL reset_fbData: got %h expected 0", fbData); end
`ifdef SYSMEM_FB_CHECKSUM_EN
    checks++; if (checksum !== '0) begin errors++; $display("[TB] FAIL reset_checksum: got %h expected 0", checksum); end
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busy, resm, wefb, done} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_idle_quiet: got %b expected 0000", {busy, resm, wefb, done}); end
  endtask

  task automatic test_full_frame();
    altPattern = 0; loadMem();
    applyStimulus(-1, 0, -1, -1, 400);
    checks++; if (timedOut) begin errors++; $display("[TB] FAIL full_timeout: got no Done expected Done"); end
    checks++; if (wrAddr.size() !== NW) begin errors++; $display("[TB] FAIL full_writes: got %0d expected %0d", wrAddr.size(), NW); end
    for (int i = 0; i < wrAddr.size() && i < NW; i++) begin
      checks++;
      if (wrAddr[i] !== FB_AW'(i) || wrData[i] !== expWord(i)) begin
        errors++; $display("[TB] FAIL full_write%0d: got addr=%0d data=%h expected addr=%0d data=%h", i, wrAddr[i], wrData[i], i, expWord(i));
      end
    end
    for (int i = 0; i < rdAddr.size() && i < NW; i++) begin
      checks++;
      if (rdAddr[i] !== SM_AW'(i)) begin errors++; $display("[TB] FAIL full_read%0d: got %0d expected %0d", i, rdAddr[i], i); end
    end
    checks++; if (doneCount !== 1) begin errors++; $display("[TB] FAIL full_doneCount: got %0d expected 1", doneCount); end
    checks++; if (doneCyc - startCyc !== 301) begin errors++; $display("[TB] FAIL full_doneLatency: got %0d expected 301", doneCyc - startCyc); end
    checks++; if (busyCount !== 300) begin errors++; $display("[TB] FAIL full_busyCycles: got %0d expected 300", busyCount); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("[TB] FAIL full_afterDone: got %b expected 00", {busy, done}); end
  endtask

  task automatic test_stall();
    altPattern = 0; loadMem();
    applyStimulus(42, 5, -1, -1, 400);
    checks++; if (timedOut) begin errors++; $display("[TB] FAIL stall_timeout: got no Done expected Done"); end
    checks++; if (stWe.size() !== 5) begin errors++; $display("[TB] FAIL stall_cycles: got %0d expected 5", stWe.size()); end
    for (int i = 0; i < stWe.size(); i++) begin
      checks++;
      if (stWe[i] !== 1'b1 || stAddr[i] !== FB_AW'(42) || stData[i] !== 24'd42) begin
        errors++; $display("[TB] FAIL stall_hold%0d: got we=%b addr=%0d data=%h expected we=1 addr=42 data=00002a", i, stWe[i], stAddr[i], stData[i]);
      end
    end
    checks++; if (wrAddr.size() !== NW) begin errors++; $display("[TB] FAIL stall_writes: got %0d expected %0d", wrAddr.size(), NW); end
    checks++; if (wrData.size() > 43 && wrData[42] !== 24'd42) begin errors++; $display("[TB] FAIL stall_word42: got %h expected 00002a", wrData[42]); end
    checks++; if (doneCyc - startCyc !== 306) begin errors++; $display("[TB] FAIL stall_doneLatency: got %0d expected 306", doneCyc - startCyc); end
    checks++; if (busyCount !== 305) begin errors++; $display("[TB] FAIL stall_busyCycles: got %0d expected 305", busyCount); end
  endtask

  task automatic test_back_to_back_start();
    altPattern = 0; loadMem();
    applyStimulus(-1, 0, 10, -1, 400);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (wrAddr.size() !== NW) begin errors++; $display("[TB] FAIL restart_writes: got %0d expected %0d", wrAddr.size(), NW); end
    checks++; if (doneCount !== 1) begin errors++; $display("[TB] FAIL restart_doneCount: got %0d expected 1", doneCount); end
    checks++; if (doneCyc - startCyc !== 301) begin errors++; $display("[TB] FAIL restart_doneLatency: got %0d expected 301", doneCyc - startCyc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL restart_notRequeued: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    altPattern = 0; loadMem();
    applyStimulus(-1, 0, -1, 57, 400);
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (dut.r_state !== IDLE) begin errors++; $display("[TB] FAIL midreset_state: got %0d expected %0d", dut.r_state, IDLE); end
    checks++; if ({busy, done, resm, wefb} !== 4'b0000) begin errors++; $display("[TB] FAIL midreset_strobes: got %b expected 0000", {busy, done, resm, wefb}); end
    checks++; if (addrSm !== '0 || addrFb !== '0 || fbData !== '0) begin errors++; $display("[TB] FAIL midreset_regs: got addrSm=%0d addrFb=%0d data=%h expected 0 0 0", addrSm, addrFb, fbData); end
    checks++; if (wrAddr.size() !== 57) begin errors++; $display("[TB] FAIL midreset_partial: got %0d expected 57", wrAddr.size()); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (doneCount !== 0) begin errors++; $display("[TB] FAIL midreset_noDone: got %0d expected 0", doneCount); end
    applyStimulus(-1, 0, -1, -1, 400);
    checks++; if (rdAddr.size() == 0 || rdAddr[0] !== '0) begin errors++; $display("[TB] FAIL midreset_restartAddr: got %0d reads expected first addr 0", rdAddr.size()); end
    checks++; if (wrAddr.size() !== NW || doneCount !== 1) begin errors++; $display("[TB] FAIL midreset_restartFrame: got %0d writes %0d done expected 100 1", wrAddr.size(), doneCount); end
  endtask

  task automatic test_pattern();
    altPattern = 1; loadMem();
    applyStimulus(-1, 0, -1, -1, 400);
    checks++; if (wrData.size() !== NW) begin errors++; $display("[TB] FAIL pattern_writes: got %0d expected %0d", wrData.size(), NW); end
    for (int i = 0; i < wrData.size() && i < NW; i += 9) begin
      checks++;
      if (wrData[i] !== expWord(i)) begin errors++; $display("[TB] FAIL pattern_word%0d: got %h expected %h", i, wrData[i], expWord(i)); end
    end
    altPattern = 0;
  endtask

  task automatic test_single_word();
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    checks++; if (s1Resm !== 1'b1 || s1AddrSm !== 3'd0 || s1Busy !== 1'b1) begin errors++; $display("[TB] FAIL single_rdReq: got resm=%b addr=%0d busy=%b expected 1 0 1", s1Resm, s1AddrSm, s1Busy); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (s1Wefb !== 1'b1 || s1AddrFb !== 2'd0 || s1FbData !== 24'hABCDEF) begin errors++; $display("[TB] FAIL single_write: got we=%b addr=%0d data=%h expected 1 0 abcdef", s1Wefb, s1AddrFb, s1FbData); end
    @(posedge clk); #1;
    checks++; if (s1Done !== 1'b1 || s1Busy !== 1'b0 || s1Wefb !== 1'b0) begin errors++; $display("[TB] FAIL single_done: got done=%b busy=%b we=%b expected 1 0 0", s1Done, s1Busy, s1Wefb); end
    @(posedge clk); #1;
    checks++; if (s1Done !== 1'b0 || s1Resm !== 1'b0) begin errors++; $display("[TB] FAIL single_oneShot: got done=%b resm=%b expected 0 0", s1Done, s1Resm); end
  endtask

`ifdef SYSMEM_FB_CHECKSUM_EN
  task automatic test_checksum();
    altPattern = 0; loadMem();
    applyStimulus(-1, 0, -1, -1, 400);
    checks++; if (checksum !== 24'd4950) begin errors++; $display("[TB] FAIL checksum_sum: got %0d expected 4950", checksum); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (checksum !== 24'd4950) begin errors++; $display("[TB] FAIL checksum_hold: got %0d expected 4950", checksum); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (checksum !== 24'd0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL checksum_clear: got %0d busy=%b expected 0 1", checksum, busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_stall();
    test_back_to_back_start();
    test_reset_mid();
    test_pattern();
    test_single_word();
`ifdef SYSMEM_FB_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
